// File: rtl/div_pkg.sv
// Shared definitions for the divider front end: op encodings, FSM states,
// response payload layout and the fixed results of the bypass cases.
package div_pkg;

  localparam int unsigned DATA_W = 32;

  // Request op encodings
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } divOp_t;

  // Front-end FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LAUNCH = 2'b01,
    ST_WAIT   = 2'b10,
    ST_RESP   = 2'b11
  } divState_t;

  // Response payload held stable while the consumer stalls
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              dbz;
    logic              err;
  } divResp_t;

  localparam logic [DATA_W-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [DATA_W-1:0] NEG_ONE  = 32'hFFFF_FFFF;
  // Divide-by-zero quotient; the remainder path returns the dividend
  localparam logic [DATA_W-1:0] DBZ_QUOT = 32'hFFFF_FFFF;
  // INT_MIN / -1 results
  localparam logic [DATA_W-1:0] OVF_QUOT = 32'h8000_0000;
  localparam logic [DATA_W-1:0] OVF_REM  = 32'h0000_0000;

  function automatic logic isSignedOp(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic isRemOp(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_sign_adjust.sv
// Combinational sign handling around an unsigned divider.
//   opA/opB, signedOp       : raw request operands and signedness
//   magA/magB               : operands to hand to the divider (|x| when signed)
//   quotRaw/remRaw          : unsigned divider results
//   negQuot/negRem          : negate the respective result
//   quotFixed/remFixed      : signed-corrected results (two's complement, mod 2^32)
module div_sign_adjust
  import div_pkg::*;
(
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        signedOp,
  output logic [31:0] magA,
  output logic [31:0] magB,
  input  logic [31:0] quotRaw,
  input  logic [31:0] remRaw,
  input  logic        negQuot,
  input  logic        negRem,
  output logic [31:0] quotFixed,
  output logic [31:0] remFixed
);

  function automatic logic [DATA_W-1:0] twosNeg(input logic [DATA_W-1:0] v);
    return DATA_W'(~v + DATA_W'(1));
  endfunction

  // Magnitudes; |INT_MIN| wraps to 0x80000000, which is correct as unsigned
  always_comb begin
    magA = opA;
    magB = opB;
    if (signedOp && opA[DATA_W-1]) magA = twosNeg(opA);
    if (signedOp && opB[DATA_W-1]) magB = twosNeg(opB);
  end

  // Result sign restoration
  always_comb begin
    quotFixed = negQuot ? twosNeg(quotRaw) : quotRaw;
    remFixed  = negRem  ? twosNeg(remRaw)  : remRaw;
  end

endmodule

// File: rtl/div_frontend.sv
// Request/response front end for an external iterative unsigned divider.
// Handles signed ops, divide-by-zero and INT_MIN/-1 without launching the
// divider, masks stale div_done right after a launch and times out a
// divider that never answers.
//   clk, rst                     : clock, synchronous active-high reset
//   req_valid/req_ready          : request handshake (op, a, b)
//   resp_valid/resp_ready        : response handshake (data, dbz, err)
//   div_dividend/div_divisor     : unsigned operands to the divider
//   div_done/quotient/remainder  : divider results
module div_frontend
  import div_pkg::*;
#(
  parameter int unsigned DONE_MASK_CYCLES = 2,
  parameter int unsigned TIMEOUT_CYCLES   = 96
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_dbz,
  output logic        resp_err,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_done,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder
);

  // LAUNCH always lasts at least one cycle since it is the operand-load state
  localparam int unsigned MASK_LAST    = (DONE_MASK_CYCLES > 0) ? DONE_MASK_CYCLES - 1 : 0;
  localparam int unsigned TIMEOUT_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int unsigned CNT_MAX      = (MASK_LAST > TIMEOUT_LAST) ? MASK_LAST : TIMEOUT_LAST;
  localparam int unsigned CNT_W        = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  divState_t        state;
  divState_t        nextState;
  logic [1:0]       opReg;
  logic             aNeg;
  logic             bNeg;
  logic [CNT_W-1:0] cnt;
  divResp_t         respReg;

  logic             reqFire;
  logic             reqSigned;
  logic             reqDbz;
  logic             reqBypass;
  logic             maskLast;
  logic             waitLast;
  logic             latchSigned;
  logic             latchRem;
  divResp_t         bypassResp;
  logic [31:0]      magA;
  logic [31:0]      magB;
  logic [31:0]      quotFixed;
  logic [31:0]      remFixed;

  div_sign_adjust uSignAdjust (
    .opA       (req_a),
    .opB       (req_b),
    .signedOp  (reqSigned),
    .magA      (magA),
    .magB      (magB),
    .quotRaw   (div_quotient),
    .remRaw    (div_remainder),
    .negQuot   (latchSigned & (aNeg ^ bNeg)),
    .negRem    (latchSigned & aNeg),
    .quotFixed (quotFixed),
    .remFixed  (remFixed)
  );

  // Request classification and counter decode
  always_comb begin
    reqSigned   = isSignedOp(req_op);
    reqDbz      = (req_b == '0);
    reqBypass   = reqDbz | (reqSigned & (req_a == INT_MIN) & (req_b == NEG_ONE));
    reqFire     = req_valid & (state == ST_IDLE);
    maskLast    = (cnt == CNT_W'(MASK_LAST));
    waitLast    = (cnt == CNT_W'(TIMEOUT_LAST));
    latchSigned = isSignedOp(opReg);
    latchRem    = isRemOp(opReg);
  end

  // Fixed results for requests that never reach the divider
  always_comb begin
    bypassResp     = '0;
    bypassResp.dbz = reqDbz;
    if (reqDbz) begin
      bypassResp.data = isRemOp(req_op) ? req_a : DBZ_QUOT;
    end else begin
      bypassResp.data = isRemOp(req_op) ? OVF_REM : OVF_QUOT;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    unique case (state)
      ST_IDLE: begin
        if (reqFire) nextState = reqBypass ? ST_RESP : ST_LAUNCH;
      end
      ST_LAUNCH: begin
        if (maskLast) nextState = ST_WAIT;
      end
      ST_WAIT: begin
        if (div_done || waitLast) nextState = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      ST_IDLE: req_ready  = 1'b1;
      ST_RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand latch, divider operands, shared mask/timeout counter, response
  always_ff @(posedge clk) begin
    if (rst) begin
      opReg        <= '0;
      aNeg         <= 1'b0;
      bNeg         <= 1'b0;
      cnt          <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      respReg      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (reqFire) begin
            opReg <= req_op;
            aNeg  <= req_a[DATA_W-1];
            bNeg  <= req_b[DATA_W-1];
            cnt   <= '0;
            if (reqBypass) begin
              respReg <= bypassResp;
            end else begin
              // Only point where the divider operands move
              div_dividend <= magA;
              div_divisor  <= magB;
            end
          end
        end
        ST_LAUNCH: begin
          cnt <= maskLast ? '0 : cnt + CNT_W'(1);
        end
        ST_WAIT: begin
          if (div_done) begin
            respReg.data <= latchRem ? remFixed : quotFixed;
            respReg.dbz  <= 1'b0;
            respReg.err  <= 1'b0;
            cnt          <= '0;
          end else if (waitLast) begin
            respReg.data <= '0;
            respReg.dbz  <= 1'b0;
            respReg.err  <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_data = respReg.data;
  assign resp_dbz  = respReg.dbz;
  assign resp_err  = respReg.err;

endmodule

// File: tb/tb_div_frontend.sv
// Self-checking bench for div_frontend with a behavioural divider and a
// response scoreboard.
module tb_div_frontend;

  localparam int MASK = 2;
  localparam int TMO  = 96;
  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;
  localparam logic [31:0] IMIN = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_dbz;
  logic        resp_err;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_done = 1'b0;
  logic [31:0] div_quotient = '0;
  logic [31:0] div_remainder = '0;

  typedef struct {
    logic [31:0] data;
    logic        dbz;
    logic        err;
    int          lat;
  } expResp_t;

  expResp_t    sb[$];
  int          numChecks = 0;
  int          numFails  = 0;
  int          cyc       = 0;
  int          doneAt    = -1;
  int          earlyAt   = -1;
  logic [31:0] expDivA   = '0;
  logic [31:0] expDivB   = '0;

  div_frontend #(.DONE_MASK_CYCLES(MASK), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_dbz(resp_dbz), .resp_err(resp_err),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: answers at absolute edge doneAt; earlyAt gives a stale pulse with junk data
  always @(negedge clk) begin
    div_done      = 1'b0;
    div_quotient  = '0;
    div_remainder = '0;
    if (cyc + 1 == earlyAt) begin
      div_done      = 1'b1;
      div_quotient  = 32'hDEAD_BEEF;
      div_remainder = 32'hDEAD_BEEF;
    end else if (cyc + 1 == doneAt) begin
      div_done = 1'b1;
      if (div_divisor != 0) begin
        div_quotient  = div_dividend / div_divisor;
        div_remainder = div_dividend % div_divisor;
      end
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mag(input logic sgn, input logic [31:0] v);
    return (sgn && v[31]) ? 32'(-$signed(v)) : v;
  endfunction

  // Reference model; doneOff == 0 means the divider never answers
  function automatic expResp_t model(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input int doneOff);
    expResp_t e;
    int sa, sbv;
    bit sgn, rem;
    sgn = (op == DIV) || (op == REM);
    rem = (op == REM) || (op == REMU);
    e.dbz = 1'b0; e.err = 1'b0; e.lat = doneOff;
    if (b == 0) begin
      e.data = rem ? a : ONES; e.dbz = 1'b1; e.lat = 0;
    end else if (sgn && a == IMIN && b == ONES) begin
      e.data = rem ? 32'd0 : IMIN; e.lat = 0;
    end else if (doneOff == 0) begin
      e.data = '0; e.err = 1'b1; e.lat = MASK + TMO;
    end else if (sgn) begin
      sa = a; sbv = b;
      e.data = rem ? 32'(sa % sbv) : 32'(sa / sbv);
    end else begin
      e.data = rem ? a % b : a / b;
    end
    return e;
  endfunction

  task automatic doOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input int doneOff, input bit early, input int hold);
    expResp_t e;
    int h;
    int waited;
    bit sgn;
    bit launch;
    sgn    = (op == DIV) || (op == REM);
    launch = !((b == 0) || (sgn && a == IMIN && b == ONES));
    @(negedge clk);
    checkVal({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    h = cyc;
    if (launch) begin
      expDivA = mag(sgn, a);
      expDivB = mag(sgn, b);
      if (doneOff > 0) doneAt = h + doneOff;
      if (early) earlyAt = h + 1;
    end
    sb.push_back(model(op, a, b, doneOff));
    @(negedge clk);
    checkVal({tag, ".div_dividend"}, div_dividend, expDivA);
    checkVal({tag, ".div_divisor"}, div_divisor, expDivB);
    waited = 0;
    while (!resp_valid && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    doneAt = -1; earlyAt = -1;
    e = sb.pop_front();
    if (!resp_valid) begin
      checkVal({tag, ".resp_valid_timeout"}, 32'(resp_valid), 32'd1);
      return;
    end
    checkVal({tag, ".latency"}, 32'(cyc - h), 32'(e.lat));
    for (int i = 0; i < hold; i++) begin
      checkVal({tag, ".hold_data"}, resp_data, e.data);
      checkVal({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
      checkVal({tag, ".hold_resp_valid"}, 32'(resp_valid), 32'd1);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    checkVal({tag, ".data"}, resp_data, e.data);
    checkVal({tag, ".dbz"}, 32'(resp_dbz), 32'(e.dbz));
    checkVal({tag, ".err"}, 32'(resp_err), 32'(e.err));
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    checkVal({tag, ".post_resp_valid"}, 32'(resp_valid), 32'd0);
    checkVal({tag, ".post_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkVal({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    checkVal({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
    checkVal({tag, ".resp_data"}, resp_data, 32'd0);
    checkVal({tag, ".resp_dbz"}, 32'(resp_dbz), 32'd0);
    checkVal({tag, ".resp_err"}, 32'(resp_err), 32'd0);
    checkVal({tag, ".div_dividend"}, div_dividend, 32'd0);
    checkVal({tag, ".div_divisor"}, div_divisor, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", numChecks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkResetState("reset");

    doOp("divu_100_7",   DIVU, 32'd100, 32'd7, 5, 1'b0, 0);
    doOp("rem_m7_2",     REM,  32'hFFFF_FFF9, 32'd2, 3, 1'b0, 0);
    doOp("div_dbz",      DIV,  32'd5, 32'd0, 0, 1'b0, 0);
    doOp("div_ovf",      DIV,  IMIN, ONES, 0, 1'b0, 0);
    doOp("rem_ovf",      REM,  IMIN, ONES, 0, 1'b0, 0);
    doOp("div_mask_hold", DIV, 32'hFFFF_FF9C, 32'd7, 6, 1'b1, 5);
    doOp("remu_dbz",     REMU, ONES, 32'd0, 0, 1'b0, 0);
    doOp("div_100_m7",   DIV,  32'd100, 32'hFFFF_FFF9, 4, 1'b0, 0);
    doOp("rem_100_m7",   REM,  32'd100, 32'hFFFF_FFF9, 3, 1'b0, 2);
    doOp("divu_big",     DIVU, IMIN, 32'd3, 7, 1'b0, 0);
    doOp("div_imin_2",   DIV,  IMIN, 32'd2, 3, 1'b0, 0);

    // Abort mid-WAIT with reset: no response may appear afterwards
    @(negedge clk);
    req_valid = 1'b1; req_op = DIVU; req_a = 32'd50; req_b = 32'd5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    doneAt = -1;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    expDivA = '0; expDivB = '0;
    @(negedge clk);
    checkResetState("rst_wait");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkVal("rst_wait.no_resp", 32'(resp_valid), 32'd0);
    end
    doOp("divu_9_3",     DIVU, 32'd9, 32'd3, 4, 1'b0, 0);
    doOp("timeout",      DIVU, 32'd10, 32'd3, 0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/div_frontend.md
DIV_FRONTEND -- requirements
Module: div_frontend

Interface
REQ-001 Parameter DONE_MASK_CYCLES, default 2: cycles after new operands are driven during which div_done is ignored.
REQ-002 Parameter TIMEOUT_CYCLES, default 96: maximum cycles spent waiting for div_done before an error response.
REQ-003 clk  in  1  sole clock; every register updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid / req_ready  in / out  1 / 1  request handshake; a transfer occurs when both are high on a clock edge.
REQ-006 req_op  in  2  00 DIV (signed), 01 DIVU, 10 REM (signed), 11 REMU.
REQ-007 req_a / req_b  in  32 / 32  dividend and divisor.
REQ-008 resp_valid / resp_ready  out / in  1 / 1  response handshake.
REQ-009 resp_data  out  32  result; resp_dbz out 1 flags divide-by-zero; resp_err out 1 flags timeout.
REQ-010 div_dividend / div_divisor  out  32 / 32  unsigned operands driven to the iterative divider.
REQ-011 div_done  in  1; div_quotient / div_remainder  in  32 / 32  divider outputs.

Function
REQ-012 FSM states: IDLE, LAUNCH, WAIT, RESP.
REQ-013 req_ready SHALL be high only in IDLE; resp_valid SHALL be high only in RESP.
REQ-014 IDLE with req_valid: latch op, a and b, then:
- b==0: go to RESP.
- signed op with a=0x80000000 and b=0xFFFFFFFF: go to RESP.
- otherwise: go to LAUNCH.
REQ-015 LAUNCH: drive |a| and |b| for signed ops (raw a and b for unsigned); ignore div_done for DONE_MASK_CYCLES cycles, then go to WAIT.
REQ-016 WAIT: on div_done=1, capture quotient and remainder, apply sign fix and go to RESP; after TIMEOUT_CYCLES cycles in WAIT, go to RESP with resp_err=1 and resp_data=0.
REQ-017 Sign fix:
- quotient is negated when the signs of a and b differ;
- remainder takes the sign of a;
- negation is two's complement, modulo 2^32.
REQ-018 Divide-by-zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return a; resp_dbz=1.
REQ-019 Signed overflow case: DIV returns 0x80000000; REM returns 0; resp_dbz=0.
REQ-020 RESP: resp_data, resp_dbz and resp_err SHALL stay stable while resp_ready=0; on handshake go to IDLE.
REQ-021 div_dividend and div_divisor SHALL change only on entry to LAUNCH and hold their value in all other states, so the divider never sees a spurious restart.
REQ-022 Latency, counted from the request handshake edge:
- bypass: resp_valid on the next cycle;
- normal: resp_valid one cycle after the first unmasked div_done.
REQ-023 A new request SHALL be accepted no earlier than the cycle after the response handshake; throughput is one operation in flight.

Reset
REQ-024 On rst: state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_dbz=0, resp_err=0, div_dividend=0, div_divisor=0, all counters=0.
REQ-025 rst asserted in any state, including mid-WAIT, SHALL abort the operation without producing a response; req_ready=1 in the cycle after rst deasserts.

Structure
REQ-026 Package div_pkg SHALL hold the op encodings, the FSM state enum, INT_MIN (0x80000000) and the divide-by-zero result constants.
REQ-027 One combinational sub-module, div_sign_adjust, SHALL perform operand absolute value and result negation; all state lives in div_frontend.
REQ-028 A single shared counter SHALL serve both the done mask and the timeout.

Verification
REQ-029 DIVU a=100, b=7 with a divider model -> resp_data=14 after div_done, resp_dbz=0.
REQ-030 REM a=0xFFFFFFF9 (-7), b=2 -> div_dividend=7, div_divisor=2, resp_data=0xFFFFFFFF (-1).
REQ-031 DIV a=5, b=0 -> resp_valid on the next cycle, resp_data=0xFFFFFFFF, resp_dbz=1, div_dividend unchanged.
REQ-032 DIV a=0x80000000, b=0xFFFFFFFF -> resp_data=0x80000000 with no divider launch; REM with the same operands -> 0.
REQ-033 resp_ready held low for 5 cycles in RESP -> resp_data stable and req_ready=0 throughout; div_done pulsed during LAUNCH mask -> ignored.
REQ-034 rst pulsed during WAIT -> no response, outputs at reset values, next DIVU 9/3 -> resp_data=3; div_done never asserted -> resp_err=1 after 96 WAIT cycles.
